// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command parser.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAY,
    GET_CHK,
    HOLD
  } parser_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;

  // One UART character (start + 8 data + stop) in clk cycles.
  function automatic int unsigned byte_time(input int unsigned clks_per_bit);
    return 10 * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Reloadable down-counter; o_expired marks the last idle cycle of the window.
module uart_byte_timer #(
  parameter int unsigned CYCLES = 8680
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  input  logic i_kick,
  output logic o_expired
);

  localparam int TW = $clog2(CYCLES) + 1;
  localparam logic [TW-1:0] LOAD = TW'(CYCLES);

  logic [TW-1:0] cnt_q;

  // Reload while idle or on any byte; otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (rst || !i_run || i_kick) cnt_q <= LOAD;
    else if (cnt_q != '0)        cnt_q <= cnt_q - TW'(1);
  end

  // The cycle that sees 1 left is the CYCLES-th cycle without a byte.
  assign o_expired = i_run && !i_kick && (cnt_q == TW'(1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/CMD/LEN/PAYLOAD/CHK byte stream into commands with valid/ready output.
module uart_cmd_parser import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT  = 217,
  parameter int unsigned MAX_LEN       = 8,
  parameter logic [7:0]  SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_BYTES = 4,
  localparam int         LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  input  logic                 i_cmd_ready,
  output logic                 o_cmd_valid,
  output logic [7:0]           o_cmd_id,
  output logic [LW-1:0]        o_cmd_len,
  output logic [8*MAX_LEN-1:0] o_payload,
  output logic                 o_err_chk,
  output logic                 o_err_len,
  output logic                 o_err_timeout,
  output logic                 o_err_overrun
);

  localparam int          IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TO_CYC    = TIMEOUT_BYTES * byte_time(CLKS_PER_BIT);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  parser_state_e state_q, state_d;

  logic [MAX_LEN-1:0][7:0] payload_q;
  logic [7:0]              id_q, chk_q;
  logic [LW-1:0]           len_q;
  logic [IW-1:0]           idx_q;
  logic                    err_chk_q, err_len_q, err_tmo_q, err_ovr_q;

  logic clr, ld_id, ld_len, st_pay, xor_chk;
  logic e_chk, e_len, e_tmo, e_ovr;
  logic tmo, run, is_sync, pay_last;

  assign run      = (state_q == GET_CMD) || (state_q == GET_LEN) ||
                    (state_q == GET_PAY) || (state_q == GET_CHK);
  assign is_sync  = i_RX_DV && (i_RX_Byte == SYNC_BYTE);
  assign pay_last = (LW'(idx_q) == len_q - LW'(1));

  uart_byte_timer #(.CYCLES(TO_CYC)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_run     (run),
    .i_kick    (i_RX_DV),
    .o_expired (tmo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath/error strobes.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ld_id   = 1'b0;
    ld_len  = 1'b0;
    st_pay  = 1'b0;
    xor_chk = 1'b0;
    e_chk   = 1'b0;
    e_len   = 1'b0;
    e_tmo   = 1'b0;
    e_ovr   = 1'b0;
    case (state_q)
      IDLE: if (is_sync) begin
        state_d = GET_CMD;
        clr     = 1'b1;
      end
      GET_CMD: if (i_RX_DV) begin
        ld_id   = 1'b1;
        state_d = GET_LEN;
      end
      GET_LEN: if (i_RX_DV) begin
        ld_len  = 1'b1;
        xor_chk = 1'b1;
        if (i_RX_Byte > MAX_LEN_B) begin
          e_len   = 1'b1;
          state_d = IDLE;
        end else if (i_RX_Byte == 8'd0) state_d = GET_CHK;
        else                              state_d = GET_PAY;
      end
      GET_PAY: if (i_RX_DV) begin
        st_pay  = 1'b1;
        xor_chk = 1'b1;
        if (pay_last) state_d = GET_CHK;
      end
      GET_CHK: if (i_RX_DV) begin
        if (i_RX_Byte == chk_q) state_d = HOLD;
        else begin
          e_chk   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        // A byte coinciding with the handshake is treated as if already idle.
        if (i_cmd_ready) begin
          state_d = IDLE;
          if (is_sync) begin
            state_d = GET_CMD;
            clr     = 1'b1;
          end
        end else if (i_RX_DV) e_ovr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Only fires on a cycle without DV, so no other strobe can be active.
    if (tmo) begin
      state_d = IDLE;
      e_tmo   = 1'b1;
    end
  end

  // Command buffer, checksum accumulator and registered error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      payload_q <= '0;
      id_q      <= '0;
      len_q     <= '0;
      chk_q     <= '0;
      idx_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      err_chk_q <= e_chk;
      err_len_q <= e_len;
      err_tmo_q <= e_tmo;
      err_ovr_q <= e_ovr;
      if (clr) begin
        payload_q <= '0;
        chk_q     <= '0;
        idx_q     <= '0;
      end
      if (ld_id) begin
        id_q  <= i_RX_Byte;
        chk_q <= i_RX_Byte;
      end
      if (ld_len)  len_q <= LW'(i_RX_Byte);
      if (xor_chk) chk_q <= chk_q ^ i_RX_Byte;
      if (st_pay) begin
        payload_q[idx_q] <= i_RX_Byte;
        idx_q            <= idx_q + IW'(1);
      end
    end
  end

  assign o_cmd_valid   = (state_q == HOLD);
  assign o_cmd_id      = id_q;
  assign o_cmd_len     = len_q;
  assign o_payload     = payload_q;
  assign o_err_chk     = err_chk_q;
  assign o_err_len     = err_len_q;
  assign o_err_timeout = err_tmo_q;
  assign o_err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: vector table, corner sequences, random frames.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 8;
  localparam logic [7:0] SYNC = 8'hAA;
  localparam logic [3:0] E_CHK = 4'b1000, E_LEN = 4'b0100, E_OVR = 4'b0001;

  logic        clk = 1'b0;
  logic        rst, dv, rdy;
  logic [7:0]  rxb;
  logic        o_cmd_valid, o_err_chk, o_err_len, o_err_timeout, o_err_overrun;
  logic [7:0]  o_cmd_id;
  logic [3:0]  o_cmd_len;
  logic [63:0] o_payload;
  logic [3:0]  errs;

  int n_cmp = 0, n_bad = 0;

  assign errs = {o_err_chk, o_err_len, o_err_timeout, o_err_overrun};

  uart_cmd_parser #(
    .CLKS_PER_BIT(4), .MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk), .rst(rst), .i_RX_DV(dv), .i_RX_Byte(rxb), .i_cmd_ready(rdy),
    .o_cmd_valid(o_cmd_valid), .o_cmd_id(o_cmd_id), .o_cmd_len(o_cmd_len),
    .o_payload(o_payload), .o_err_chk(o_err_chk), .o_err_len(o_err_len),
    .o_err_timeout(o_err_timeout), .o_err_overrun(o_err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           n;
    logic [127:0] b;    // byte j in b[8*j +: 8]
    logic [3:0]   e;    // {chk,len,tmo,ovr} after the last byte
    logic         v;
    logic [7:0]   id;
    logic [3:0]   len;
    logic [63:0]  pay;
  } vec_t;

  vec_t tbl[7];

  // Reference model state: frame-level view of the byte stream.
  logic [7:0]  fr[$];
  bit          in_fr, holding;
  logic [7:0]  m_id;
  logic [3:0]  m_len;
  logic [63:0] m_pay;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); dv = 1'b1; rxb = b;
    @(negedge clk); dv = 1'b0; rxb = 8'h00;
  endtask

  task automatic handshake(input string nm);
    @(negedge clk); rdy = 1'b1;
    @(negedge clk); rdy = 1'b0;
    chk({nm, "_drop"}, {errs, o_cmd_valid}, 5'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, o_cmd_valid, 0);
    chk({nm, "_errs"}, errs, 0);
    chk({nm, "_id"}, o_cmd_id, 0);
    chk({nm, "_len"}, o_cmd_len, 0);
    chk({nm, "_pay"}, o_payload, 0);
  endtask

  task automatic run_vec(input int i);
    logic [127:0] bb;
    bb = tbl[i].b;
    for (int j = 0; j < tbl[i].n; j++) begin
      send(bb[8*j +: 8]);
      if (j < tbl[i].n - 1)
        chk($sformatf("v%0d_b%0d", i, j), {errs, o_cmd_valid}, 5'b0);
      else begin
        chk($sformatf("v%0d_resp", i), {errs, o_cmd_valid}, {tbl[i].e, tbl[i].v});
        if (tbl[i].v) begin
          chk($sformatf("v%0d_id", i), o_cmd_id, tbl[i].id);
          chk($sformatf("v%0d_len", i), o_cmd_len, tbl[i].len);
          chk($sformatf("v%0d_pay", i), o_payload, tbl[i].pay);
        end
      end
    end
    if (tbl[i].v) handshake($sformatf("v%0d", i));
  endtask

  // Model: one received byte while ready is low; returns expected error pulse.
  task automatic ref_byte(input logic [7:0] b, output logic [3:0] e);
    logic [7:0] x;
    e = 4'b0;
    if (holding) begin e = E_OVR; return; end
    if (!in_fr) begin
      if (b == SYNC) begin in_fr = 1; fr.delete(); end
      return;
    end
    fr.push_back(b);
    if (fr.size() == 2 && fr[1] > MAX_LEN) begin e = E_LEN; in_fr = 0; return; end
    if (fr.size() >= 2 && fr.size() == int'(fr[1]) + 3) begin
      x = 8'h00;
      for (int i = 0; i < fr.size() - 1; i++) x ^= fr[i];
      in_fr = 0;
      if (x == fr[fr.size()-1]) begin
        holding = 1;
        m_id    = fr[0];
        m_len   = fr[1][3:0];
        m_pay   = '0;
        for (int i = 0; i < int'(fr[1]); i++) m_pay[8*i +: 8] = fr[2+i];
      end else e = E_CHK;
    end
  endtask

  task automatic rsend(input logic [7:0] b);
    logic [3:0] e;
    send(b);
    ref_byte(b, e);
    chk("rnd_resp", {errs, o_cmd_valid}, {e, holding});
    if (holding) begin
      chk("rnd_id", o_cmd_id, m_id);
      chk("rnd_len", o_cmd_len, m_len);
      chk("rnd_pay", o_payload, m_pay);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  initial begin
    int got;
    logic [7:0] cmd, len, x, b;
    logic [7:0] pl[$];

    tbl[0] = '{n:6, b:128'h2122_1102_10AA, e:4'b0, v:1'b1, id:8'h10, len:4'd2, pay:64'h2211};
    tbl[1] = '{n:6, b:128'h2422_1102_10AA, e:E_CHK, v:1'b0, id:8'h0, len:4'd0, pay:64'h0};
    tbl[2] = '{n:3, b:128'h09_01AA, e:E_LEN, v:1'b0, id:8'h0, len:4'd0, pay:64'h0};
    tbl[3] = '{n:5, b:128'h58_5A01_03AA, e:4'b0, v:1'b1, id:8'h03, len:4'd1, pay:64'h5A};
    tbl[4] = '{n:8, b:128'h2201_AAAA_0320_AA55, e:4'b0, v:1'b1, id:8'h20, len:4'd3, pay:64'h01AAAA};
    tbl[5] = '{n:12, b:128'h0C08_0706_0504_0302_0108_0CAA, e:4'b0, v:1'b1, id:8'h0C, len:4'd8,
               pay:64'h0807_0605_0403_0201};
    tbl[6] = '{n:3, b:128'h09_0CAA, e:E_LEN, v:1'b0, id:8'h0, len:4'd0, pay:64'h0};

    rst = 1'b1; dv = 1'b0; rxb = 8'h00; rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Ready already high: valid lasts exactly one cycle.
    rdy = 1'b1;
    send(SYNC); send(8'h10); send(8'h02); send(8'h11); send(8'h22); send(8'h21);
    chk("t1_valid", o_cmd_valid, 1);
    chk("t1_id", o_cmd_id, 8'h10);
    chk("t1_pay", o_payload, 64'h2211);
    @(negedge clk);
    chk("t1_valid_1cyc", o_cmd_valid, 0);
    rdy = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Held command, then an overrun byte, then release.
    send(SYNC); send(8'h05); send(8'h00); send(8'h05);
    repeat (20) @(negedge clk);
    chk("t2_hold", {o_cmd_valid, o_cmd_id, o_cmd_len}, {1'b1, 8'h05, 4'd0});
    send(8'h77);
    chk("t2_overrun", {errs, o_cmd_valid}, {E_OVR, 1'b1});
    @(negedge clk);
    chk("t2_ovr_pulse", errs, 0);
    handshake("t2");

    // Inter-byte timeout mid-payload: 160 idle clocks.
    send(SYNC); send(8'h10); send(8'h02); send(8'h11);
    got = -1;
    for (int k = 1; k <= 400 && got < 0; k++) begin
      @(negedge clk);
      if (o_err_timeout) got = k;
    end
    chk("t4_tmo_cycle", got, 160);
    @(negedge clk);
    chk("t4_tmo_pulse", errs, 0);
    run_vec(0);

    // Reset mid-frame.
    send(SYNC); send(8'h10);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk_zero("t5_rst");
    run_vec(3);

    // Handshake and SYNC in the same cycle.
    send(SYNC); send(8'h05); send(8'h00); send(8'h05);
    chk("t6_hold", o_cmd_valid, 1);
    @(negedge clk); dv = 1'b1; rxb = SYNC; rdy = 1'b1;
    @(negedge clk); dv = 1'b0; rxb = 8'h00; rdy = 1'b0;
    chk("t6_no_ovr", {errs, o_cmd_valid}, 5'b0);
    send(8'h07); send(8'h00); send(8'h07);
    chk("t6_valid", {o_cmd_valid, o_cmd_id, o_cmd_len}, {1'b1, 8'h07, 4'd0});
    handshake("t6");

    // Random frames against the model.
    in_fr = 0; holding = 0;
    for (int f = 0; f < 80; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h55;
        rsend(b);
      end
      cmd = 8'($urandom);
      len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(9, 15)) : 8'($urandom_range(0, MAX_LEN));
      pl.delete();
      x = cmd ^ len;
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        pl.push_back(b);
        x ^= b;
      end
      if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
      rsend(SYNC); rsend(cmd); rsend(len);
      foreach (pl[i]) rsend(pl[i]);
      rsend(x);
      if (holding) begin
        if ($urandom_range(0, 1) == 1) rsend(8'($urandom));
        holding = 0;
        handshake("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
